// File: rtl/game_369_monitor.sv
// Monitors an upstream 3-6-9 counter: locks on 0, checks legal steps, counts claps and wraps,
// exposes the last accepted value in BCD and latches the first illegal value.
module game_369_monitor #(
    parameter int unsigned CLAP_W = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              en,
    input  logic [3:0]        count_in,
    output logic              clap,
    output logic [CLAP_W-1:0] clap_total,
    output logic [3:0]        wraps,
    output logic              tens,
    output logic [3:0]        ones,
    output logic              locked,
    output logic              err,
    output logic [3:0]        err_val
);

    typedef enum logic [1:0] {StWait0, StTrack, StFault} state_e;

    state_e            state_q, state_d;
    logic [3:0]        prev_q, prev_d;
    logic              clap_q, clap_d;
    logic [CLAP_W-1:0] clap_total_q, clap_total_d;
    logic [3:0]        wraps_q, wraps_d;
    logic              tens_q, tens_d;
    logic [3:0]        ones_q, ones_d;
    logic              locked_q, locked_d;
    logic              err_q, err_d;
    logic [3:0]        err_val_q, err_val_d;

    logic legal;
    logic is_wrap;

    always_comb begin
        legal = ((prev_q == 4'd0)  && (count_in == 4'd3))  ||
                ((prev_q == 4'd3)  && (count_in == 4'd6))  ||
                ((prev_q == 4'd6)  && (count_in == 4'd9))  ||
                ((prev_q == 4'd9)  && (count_in == 4'd13)) ||
                ((prev_q == 4'd13) && (count_in == 4'd6));
        is_wrap = (prev_q == 4'd13) && (count_in == 4'd6);
    end

    always_comb begin
        state_d      = state_q;
        prev_d       = prev_q;
        clap_d       = 1'b0;
        clap_total_d = clap_total_q;
        wraps_d      = wraps_q;
        tens_d       = tens_q;
        ones_d       = ones_q;
        err_val_d    = err_val_q;

        if (en) begin
            unique case (state_q)
                StWait0: begin
                    if (count_in == 4'd0) begin
                        state_d = StTrack;
                        prev_d  = 4'd0;
                        tens_d  = 1'b0;
                        ones_d  = 4'd0;
                    end
                end
                StTrack: begin
                    if (legal) begin
                        prev_d = count_in;
                        clap_d = 1'b1;
                        if (count_in >= 4'd10) begin
                            tens_d = 1'b1;
                            ones_d = count_in - 4'd10;
                        end else begin
                            tens_d = 1'b0;
                            ones_d = count_in;
                        end
                        if (clap_total_q != {CLAP_W{1'b1}}) begin
                            clap_total_d = clap_total_q + CLAP_W'(1);
                        end
                        if (is_wrap && (wraps_q != 4'd15)) begin
                            wraps_d = wraps_q + 4'd1;
                        end
                    end else begin
                        state_d   = StFault;
                        err_val_d = count_in;
                    end
                end
                StFault: begin
                    // Sticky until reset; samples are ignored.
                end
                default: state_d = StWait0;
            endcase
        end

        locked_d = (state_d == StTrack);
        err_d    = (state_d == StFault);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= StWait0;
            prev_q       <= 4'd0;
            clap_q       <= 1'b0;
            clap_total_q <= '0;
            wraps_q      <= 4'd0;
            tens_q       <= 1'b0;
            ones_q       <= 4'd0;
            locked_q     <= 1'b0;
            err_q        <= 1'b0;
            err_val_q    <= 4'd0;
        end else begin
            state_q      <= state_d;
            prev_q       <= prev_d;
            clap_q       <= clap_d;
            clap_total_q <= clap_total_d;
            wraps_q      <= wraps_d;
            tens_q       <= tens_d;
            ones_q       <= ones_d;
            locked_q     <= locked_d;
            err_q        <= err_d;
            err_val_q    <= err_val_d;
        end
    end

    assign clap       = clap_q;
    assign clap_total = clap_total_q;
    assign wraps      = wraps_q;
    assign tens       = tens_q;
    assign ones       = ones_q;
    assign locked     = locked_q;
    assign err        = err_q;
    assign err_val    = err_val_q;

endmodule

// File: tb/tb_game_369_monitor.sv
// Directed bench for game_369_monitor; a CLAP_W=2 copy shares the stimulus to check saturation.
module tb_game_369_monitor;

    logic       clk = 1'b0;
    logic       reset;
    logic       en;
    logic [3:0] count_in;

    logic       clap, tens, locked, err;
    logic [7:0] clap_total;
    logic [3:0] wraps, ones, err_val;

    logic       clap2, tens2, locked2, err2;
    logic [1:0] clap_total2;
    logic [3:0] wraps2, ones2, err_val2;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    game_369_monitor #(.CLAP_W(8)) dut (
        .clk(clk), .reset(reset), .en(en), .count_in(count_in),
        .clap(clap), .clap_total(clap_total), .wraps(wraps), .tens(tens), .ones(ones),
        .locked(locked), .err(err), .err_val(err_val)
    );

    game_369_monitor #(.CLAP_W(2)) dut2 (
        .clk(clk), .reset(reset), .en(en), .count_in(count_in),
        .clap(clap2), .clap_total(clap_total2), .wraps(wraps2), .tens(tens2), .ones(ones2),
        .locked(locked2), .err(err2), .err_val(err_val2)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Drive on the falling edge, then sample 1 time unit after the rising edge.
    task automatic step(input logic r, input logic e, input logic [3:0] v);
        @(negedge clk);
        reset    = r;
        en       = e;
        count_in = v;
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, "_clap"}, 32'(clap), 0);
        check({tag, "_total"}, 32'(clap_total), 0);
        check({tag, "_wraps"}, 32'(wraps), 0);
        check({tag, "_tens"}, 32'(tens), 0);
        check({tag, "_ones"}, 32'(ones), 0);
        check({tag, "_locked"}, 32'(locked), 0);
        check({tag, "_err"}, 32'(err), 0);
        check({tag, "_errval"}, 32'(err_val), 0);
    endtask

    initial begin
        logic [3:0] seq [9];
        int exp_total;
        int exp2;
        seq = '{4'd0, 4'd3, 4'd6, 4'd9, 4'd13, 4'd6, 4'd9, 4'd13, 4'd6};
        reset = 1'b1;
        en = 1'b0;
        count_in = 4'd0;

        // Reset state
        step(1'b1, 1'b0, 4'd0);
        step(1'b1, 1'b1, 4'd3);
        check_reset_state("rst");
        check("rst_total2", 32'(clap_total2), 0);

        // Main sequence 0,3,6,9,13,6,9,13,6
        step(1'b0, 1'b1, seq[0]);
        check("lock_after0", 32'(locked), 1);
        check("noclap_on0", 32'(clap), 0);
        exp_total = 0;
        for (int i = 1; i < 9; i++) begin
            step(1'b0, 1'b1, seq[i]);
            exp_total++;
            exp2 = (exp_total > 3) ? 3 : exp_total;
            check($sformatf("seq_clap%0d", i), 32'(clap), 1);
            check($sformatf("seq_total%0d", i), 32'(clap_total), 32'(exp_total));
            check($sformatf("sat_total2_%0d", i), 32'(clap_total2), 32'(exp2));
            check($sformatf("sat_clap2_%0d", i), 32'(clap2), 1);
            if (seq[i] == 4'd13) begin
                check($sformatf("bcd13_tens%0d", i), 32'(tens), 1);
                check($sformatf("bcd13_ones%0d", i), 32'(ones), 3);
            end
        end
        check("seq_wraps", 32'(wraps), 2);
        check("seq_tens", 32'(tens), 0);
        check("seq_ones", 32'(ones), 6);
        check("seq_err", 32'(err), 0);

        // Drive wraps into saturation: 15 more 6->9->13->6 loops
        for (int k = 0; k < 15; k++) begin
            step(1'b0, 1'b1, 4'd9);
            step(1'b0, 1'b1, 4'd13);
            step(1'b0, 1'b1, 4'd6);
        end
        check("wraps_sat", 32'(wraps), 15);
        check("total_53", 32'(clap_total), 53);
        check("total2_sat", 32'(clap_total2), 3);

        // Illegal 6->13 faults; following 9 ignored
        step(1'b0, 1'b1, 4'd13);
        check("fault_err", 32'(err), 1);
        check("fault_errval", 32'(err_val), 13);
        check("fault_locked", 32'(locked), 0);
        check("fault_noclap", 32'(clap), 0);
        check("fault_total_hold", 32'(clap_total), 53);
        check("fault_ones_hold", 32'(ones), 6);
        step(1'b0, 1'b1, 4'd9);
        check("fault_sticky", 32'(err), 1);
        check("fault_errval_hold", 32'(err_val), 13);
        check("fault_noclap2", 32'(clap), 0);

        // Reset from FAULT, then build clap_total=5, wraps=1
        step(1'b1, 1'b1, 4'd3);
        check_reset_state("rstfault");
        step(1'b0, 1'b1, 4'd0);
        for (int i = 1; i < 6; i++) step(1'b0, 1'b1, seq[i]);
        check("pre_total5", 32'(clap_total), 5);
        check("pre_wraps1", 32'(wraps), 1);
        check("pre_locked", 32'(locked), 1);
        step(1'b1, 1'b1, 4'd0);
        check_reset_state("rsttrack");
        step(1'b0, 1'b1, 4'd3);
        check("wait0_3_locked", 32'(locked), 0);
        check("wait0_3_clap", 32'(clap), 0);
        check("wait0_3_err", 32'(err), 0);

        // 5 and 7 ignored in WAIT0, then 0,3
        step(1'b0, 1'b1, 4'd5);
        check("ign5_locked", 32'(locked), 0);
        step(1'b0, 1'b1, 4'd7);
        check("ign7_err", 32'(err), 0);
        step(1'b0, 1'b1, 4'd0);
        check("lock0", 32'(locked), 1);
        step(1'b0, 1'b1, 4'd3);
        check("c3_clap", 32'(clap), 1);
        check("c3_ones", 32'(ones), 3);
        check("c3_tens", 32'(tens), 0);
        check("c3_err", 32'(err), 0);
        check("c3_total", 32'(clap_total), 1);

        // en gaps: garbage ignored, clap drops
        step(1'b0, 1'b0, 4'd9);
        check("gap1_clap", 32'(clap), 0);
        check("gap1_err", 32'(err), 0);
        check("gap1_ones", 32'(ones), 3);
        step(1'b0, 1'b0, 4'd15);
        check("gap2_clap", 32'(clap), 0);
        check("gap2_locked", 32'(locked), 1);
        step(1'b0, 1'b1, 4'd6);
        check("c6_clap", 32'(clap), 1);
        check("c6_ones", 32'(ones), 6);
        check("c6_total", 32'(clap_total), 2);

        // Value >13 is illegal
        step(1'b0, 1'b1, 4'd15);
        check("big_err", 32'(err), 1);
        check("big_errval", 32'(err_val), 15);
        check("big_clap", 32'(clap), 0);
        check("big_total_hold", 32'(clap_total), 2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
